// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if
//   Control, serial-data and result signals of the parametrised pattern
//   detector. CLK and RST are not part of this bundle.
//   slave  : detector side (receives controls and data, drives results)
//   master : stream/control side (drives controls and data, observes results)
//   Signals: En, In1, In1Valid, Overlap, PatLoad, PatIn, MaskIn, CntClr
//            -> detector; Out1, MatchCnt, State <- detector.
interface seq_detector_param_if #(
    parameter int unsigned PAT_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 En;
    logic                 In1;
    logic                 In1Valid;
    logic                 Overlap;
    logic                 PatLoad;
    logic [PAT_WIDTH-1:0] PatIn;
    logic [PAT_WIDTH-1:0] MaskIn;
    logic                 CntClr;
    logic                 Out1;
    logic [CNT_WIDTH-1:0] MatchCnt;
    logic [1:0]           State;

    modport slave (
        input  En, In1, In1Valid, Overlap, PatLoad, PatIn, MaskIn, CntClr,
        output Out1, MatchCnt, State
    );

    modport master (
        output En, In1, In1Valid, Overlap, PatLoad, PatIn, MaskIn, CntClr,
        input  Out1, MatchCnt, State
    );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial pattern detector. Compares the most recent PAT_WIDTH qualified
//   bits (newest bit = bit 0) against a loadable pattern under a per-bit
//   compare mask, in overlapping or non-overlapping mode. Produces a
//   registered one-cycle match pulse and a saturating match counter.
//   Ports:
//     CLK  - clock, rising edge
//     RST  - synchronous active-high reset
//     bus  - slave modport: En, In1, In1Valid, Overlap, PatLoad, PatIn,
//            MaskIn, CntClr in; Out1, MatchCnt, State out
module seq_detector_param #(
    parameter int unsigned          PAT_WIDTH  = 4,
    parameter int unsigned          CNT_WIDTH  = 8,
    parameter logic [PAT_WIDTH-1:0] PAT_RESET  = PAT_WIDTH'(4'b1011),
    parameter logic [PAT_WIDTH-1:0] MASK_RESET = '1
) (
    input  logic                 CLK,
    input  logic                 RST,
    seq_detector_param_if.slave  bus
);
    localparam int unsigned          FW        = $clog2(PAT_WIDTH + 1);
    localparam logic [FW-1:0]        FILL_LAST = FW'(PAT_WIDTH - 1);
    localparam logic [FW-1:0]        FILL_FULL = FW'(PAT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FILL   = 2'b01,
        DETECT = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    // Only PAT_WIDTH-1 bits of history are stored: the incoming bit
    // completes the compare window, and the oldest bit would only be
    // shifted out without ever being compared again.
    logic [PAT_WIDTH-2:0]   hist_q, hist_d;
    logic [PAT_WIDTH-1:0]   pat_q, pat_d;
    logic [PAT_WIDTH-1:0]   mask_q, mask_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic                   out1_q, out1_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [PAT_WIDTH-1:0]   window;
    logic                   consume;
    logic                   complete;
    logic                   hit;

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        pat_d    = pat_q;
        mask_d   = mask_q;
        fill_d   = fill_q;
        out1_d   = 1'b0;
        cnt_d    = cnt_q;
        consume  = 1'b0;
        complete = 1'b0;
        hit      = 1'b0;
        window   = {hist_q, bus.In1};

        if (bus.PatLoad) begin
            // New pattern: history restarts and any same-cycle bit is dropped.
            pat_d   = bus.PatIn;
            mask_d  = bus.MaskIn;
            hist_d  = '0;
            fill_d  = '0;
            state_d = bus.En ? FILL : IDLE;
        end else if (!bus.En) begin
            state_d = IDLE;
            hist_d  = '0;
            fill_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FILL;
                    consume = bus.In1Valid;
                end
                FILL, DETECT: consume = bus.In1Valid;
                default: consume = 1'b0;
            endcase

            if (consume) begin
                hist_d   = window[PAT_WIDTH-2:0];
                // fill_q is held at PAT_WIDTH while in DETECT.
                complete = (state_q == DETECT) || (fill_q == FILL_LAST);
                if (!complete) begin
                    fill_d = fill_q + FW'(1);
                end else begin
                    hit    = ((window ^ pat_q) & mask_q) == '0;
                    out1_d = hit;
                    if (hit && !bus.Overlap) begin
                        state_d = FILL;
                        fill_d  = '0;
                    end else begin
                        state_d = DETECT;
                        fill_d  = FILL_FULL;
                    end
                end
            end
        end

        // Encoding 2'b11 is unreachable; if seen, return to a clean IDLE.
        if (state_q != IDLE && state_q != FILL && state_q != DETECT) begin
            state_d = IDLE;
            hist_d  = '0;
            fill_d  = '0;
            out1_d  = 1'b0;
            hit     = 1'b0;
        end

        if (bus.CntClr) begin
            cnt_d = '0;
        end else if (hit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            hist_q  <= '0;
            pat_q   <= PAT_RESET;
            mask_q  <= MASK_RESET;
            fill_q  <= '0;
            out1_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            fill_q  <= fill_d;
            out1_q  <= out1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Out1     = out1_q;
    assign bus.MatchCnt = cnt_q;
    assign bus.State    = state_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
//   Directed-vector bench for seq_detector_param (PAT_WIDTH=4, CNT_WIDTH=2).
//   Each stimulus cycle pushes the hand-computed Out1/MatchCnt/State expected
//   after the next rising edge; a monitor on the falling edge pops and compares.
module tb_seq_detector_param;
    localparam int unsigned PW = 4;
    localparam int unsigned CW = 2;
    localparam logic [1:0]  SI = 2'b00;
    localparam logic [1:0]  SF = 2'b01;
    localparam logic [1:0]  SD = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

    seq_detector_param #(
        .PAT_WIDTH (PW),
        .CNT_WIDTH (CW),
        .PAT_RESET (4'b1011),
        .MASK_RESET(4'b1111)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int         at;
        int         id;
        logic       out1;
        int         cnt;
        logic [1:0] st;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         cyc     = 0;
    int         checks  = 0;
    int         passed  = 0;
    int         step_id = 0;
    logic       pl;
    logic       clr;
    logic [3:0] pin;
    logic [3:0] min;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int id, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s step %0d: got %0d want %0d", name, id, got, want);
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            check("Out1",     e.id, int'(bus.Out1),     int'(e.out1));
            check("MatchCnt", e.id, int'(bus.MatchCnt), e.cnt);
            check("State",    e.id, int'(bus.State),    int'(e.st));
        end
    end

    // One clock of stimulus; pl/clr/rst/pin/min are set by the caller beforehand.
    task automatic step(input logic en, input logic v, input logic b, input logic ovl,
                        input logic eo, input int ec, input logic [1:0] es);
        bus.En       = en;
        bus.In1Valid = v;
        bus.In1      = b;
        bus.Overlap  = ovl;
        bus.PatLoad  = pl;
        bus.PatIn    = pin;
        bus.MaskIn   = min;
        bus.CntClr   = clr;
        q.push_back('{cyc + 1, step_id, eo, ec, es});
        step_id++;
        @(posedge clk);
        #1;
        pl  = 1'b0;
        clr = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pl = 1'b0; clr = 1'b0; pin = '0; min = '0;
        bus.En = 1'b0; bus.In1 = 1'b0; bus.In1Valid = 1'b0; bus.Overlap = 1'b0;
        bus.PatLoad = 1'b0; bus.PatIn = '0; bus.MaskIn = '0; bus.CntClr = 1'b0;
        @(posedge clk);
        #1;

        // Reset (second cycle with En=1 and a valid bit), then idle stream
        rst = 1'b1; step(0, 0, 0, 0, 0, 0, SI);
        rst = 1'b1; step(1, 1, 1, 1, 0, 0, SI);
        step(0, 1, 1, 1, 0, 0, SI);
        step(0, 1, 0, 1, 0, 0, SI);
        step(0, 1, 1, 1, 0, 0, SI);

        // Overlap: 1,0,1,1,0,1,1 against 1011
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 0, 1, 0, 0, SF);
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 1, 1, 1, 1, SD);
        step(1, 1, 0, 1, 0, 1, SD);
        step(1, 1, 1, 1, 0, 1, SD);
        step(1, 1, 1, 1, 1, 2, SD);
        step(0, 0, 0, 1, 0, 2, SI);
        clr = 1'b1; step(0, 0, 0, 1, 0, 0, SI);

        // Non-overlap: same stream, only the first window matches
        step(1, 1, 1, 0, 0, 0, SF);
        step(1, 1, 0, 0, 0, 0, SF);
        step(1, 1, 1, 0, 0, 0, SF);
        step(1, 1, 1, 0, 1, 1, SF);
        step(1, 1, 0, 0, 0, 1, SF);
        step(1, 1, 1, 0, 0, 1, SF);
        step(1, 1, 1, 0, 0, 1, SF);
        step(0, 0, 0, 0, 0, 1, SI);
        clr = 1'b1; step(0, 0, 0, 0, 0, 0, SI);

        // Don't-care mask: pattern 1011, mask 1110
        pl = 1'b1; pin = 4'b1011; min = 4'b1110; step(0, 0, 0, 1, 0, 0, SI);
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 0, 1, 0, 0, SF);
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 0, 1, 1, 1, SD);
        step(0, 0, 0, 1, 0, 1, SI);
        step(1, 1, 0, 1, 0, 1, SF);
        step(1, 1, 0, 1, 0, 1, SF);
        step(1, 1, 1, 1, 0, 1, SF);
        step(1, 1, 0, 1, 0, 1, SD);
        clr = 1'b1; step(0, 0, 0, 1, 0, 0, SI);

        // Saturation of the 2-bit counter, then CntClr colliding with a match
        pl = 1'b1; pin = 4'b1111; min = 4'b1111; step(0, 0, 0, 1, 0, 0, SI);
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 1, 1, 1, 1, SD);
        step(1, 1, 1, 1, 1, 2, SD);
        step(1, 1, 1, 1, 1, 3, SD);
        step(1, 1, 1, 1, 1, 3, SD);
        step(1, 1, 1, 1, 1, 3, SD);
        clr = 1'b1; step(1, 1, 1, 1, 1, 0, SD);
        step(1, 0, 1, 1, 0, 0, SD);

        // PatLoad together with a valid bit mid-FILL: bit discarded, fill restarts
        step(0, 0, 0, 1, 0, 0, SI);
        step(1, 1, 0, 1, 0, 0, SF);
        step(1, 1, 1, 1, 0, 0, SF);
        pl = 1'b1; pin = 4'b0110; min = 4'b1111; step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 0, 1, 0, 0, SF);
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 0, 1, 1, 1, SD);

        // In1Valid gaps (with In1=1 during the gaps) inside the pattern
        step(0, 0, 0, 1, 0, 1, SI);
        step(1, 1, 0, 1, 0, 1, SF);
        step(1, 0, 1, 1, 0, 1, SF);
        step(1, 1, 1, 1, 0, 1, SF);
        step(1, 0, 1, 1, 0, 1, SF);
        step(1, 1, 1, 1, 0, 1, SF);
        step(1, 1, 0, 1, 1, 2, SD);

        // En dropped mid-pattern: history must be rebuilt from scratch
        step(0, 0, 0, 1, 0, 2, SI);
        step(1, 1, 0, 1, 0, 2, SF);
        step(1, 1, 1, 1, 0, 2, SF);
        step(0, 1, 1, 1, 0, 2, SI);
        step(1, 1, 1, 1, 0, 2, SF);
        step(1, 1, 0, 1, 0, 2, SF);
        step(1, 1, 0, 1, 0, 2, SF);
        step(1, 1, 1, 1, 0, 2, SD);
        step(1, 1, 1, 1, 0, 2, SD);
        step(1, 1, 0, 1, 1, 3, SD);

        // Reset mid-operation restores the reset pattern 1011
        rst = 1'b1; step(1, 1, 1, 1, 0, 0, SI);
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 0, 1, 0, 0, SF);
        step(1, 1, 1, 1, 0, 0, SF);
        step(1, 1, 1, 1, 1, 1, SD);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: pending %0d want 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
